// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default baud divisor and
// parity-mode constants used by both the receiver and the future transmitter.
package uart_pkg;

  localparam int unsigned DEFAULT_BAUD_DIV = 5208;

  localparam bit PARITY_MODE_EVEN = 1'b0;
  localparam bit PARITY_MODE_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Width of a down-counter that must hold the value div.
  function automatic int unsigned baud_cnt_width(input int unsigned div);
    return $clog2(div + 1);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Consumer-side bundle of the UART receiver: received word, flags and the
// acknowledge that clears them.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);

  logic                 clr_rdy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rdy;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  // Receiver side: presents the word and flags, accepts the acknowledge.
  modport master (
    output rx_data, rdy, parity_err, frame_err, overrun,
    input  clr_rdy
  );

  // Consumer side: reads the word and flags, drives the acknowledge.
  modport slave (
    input  rx_data, rdy, parity_err, frame_err, overrun,
    output clr_rdy
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter. tick is high during the single cycle in which the
// count is 1, so the edge that ends that cycle is the terminal-count edge;
// the count then rests at 0 until reloaded.
module uart_baud_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise decrement until resting at zero.
  // NOTE: always_comb assigns every output a default first so no path leaves a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Count register.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: two-flop synchroniser, mid-bit sampling FSM with
// false-start rejection, LSB-first shift register, and a registered output
// stage holding the word with parity/framing/overrun flags until acknowledged.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = int'(DEFAULT_BAUD_DIV),
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          RX,
  uart_rx_cfg_if.master rx_if
);

  localparam int               CNT_W     = int'(baud_cnt_width(BAUD_DIV));
  localparam logic [CNT_W-1:0] HALF_VAL  = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] FULL_VAL  = CNT_W'(BAUD_DIV);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic             PAR_MODE  = (PARITY_ODD != 0) ? PARITY_MODE_ODD
                                                             : PARITY_MODE_EVEN;

  // Synchroniser.
  logic [1:0] sync_q, sync_d;
  logic       rx_s;

  // Frame FSM and datapath.
  rx_state_t            state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 done_q, done_d;

  // Baud counter control.
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             tick;

  // Output registers.
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rdy_q, rdy_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  uart_baud_cnt #(
    .WIDTH(CNT_W)
  ) u_baud_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .load_val(cnt_val),
    .tick    (tick)
  );

  // Shift the raw line through two flops before any decision uses it.
  always_comb begin
    sync_d = {sync_q[0], RX};
  end

  assign rx_s = sync_q[1];

  // Synchroniser flops idle high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Frame sequencing: each baud tick is one sample point.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    done_d     = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = FULL_VAL;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d    = START;
          cnt_load   = 1'b1;
          cnt_val    = HALF_VAL;
          bit_cnt_d  = '0;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end

      START: begin
        if (tick) begin
          if (rx_s) begin
            // Line went back high by mid-bit: a glitch, not a start bit.
            state_d = IDLE;
          end else begin
            state_d  = DATA;
            cnt_load = 1'b1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          shift_d  = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_load = 1'b1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      PARITY: begin
        if (tick) begin
          perr_acc_d = ((^shift_q) ^ rx_s) != PAR_MODE;
          cnt_load   = 1'b1;
          state_d    = STOP;
        end
      end

      STOP: begin
        if (tick) begin
          if (!rx_s) begin
            ferr_acc_d = 1'b1;
          end
          if (bit_cnt_q == LAST_STOP) begin
            // Leave at mid-bit so the next falling edge is caught promptly.
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            cnt_load  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // FSM, shift register and per-frame accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      done_q     <= done_d;
    end
  end

  // Deliver a finished frame, or clear flags on acknowledge; delivery wins.
  always_comb begin
    rx_data_d    = rx_data_q;
    rdy_d        = rdy_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;

    if (done_q) begin
      rx_data_d    = shift_q;
      parity_err_d = perr_acc_q;
      frame_err_d  = ferr_acc_q;
      rdy_d        = 1'b1;
      overrun_d    = rx_if.clr_rdy ? 1'b0 : (rdy_q | overrun_q);
    end else if (rx_if.clr_rdy) begin
      rdy_d        = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  // Output registers seen by the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q    <= '0;
      rdy_q        <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_data_q    <= rx_data_d;
      rdy_q        <= rdy_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_if.rx_data    = rx_data_q;
  assign rx_if.rdy        = rdy_q;
  assign rx_if.parity_err = parity_err_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.overrun    = overrun_q;

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver for the serial front end; the next generation of our fixed 8N1 receiver. It converts an asynchronous RX line into parallel words with configurable baud divisor, data width, optional parity and 1 or 2 stop bits. It performs mid-bit sampling with false-start rejection and reports parity, framing and overrun errors alongside `rdy`. Consumers (command decoder, FIFOs) read `rx_data` and flags on `rdy` and acknowledge with `clr_rdy`.

## Interface
- BAUD_DIV, 5208: clock cycles per bit; legal range ≥ 4.
- DATA_BITS, 8: data bits per frame; legal range 5–9.
- PARITY_EN, 0: 1 = a parity bit follows the data.
- PARITY_ODD, 0: 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1: number of stop bits; 1 or 2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- RX  in  1  asynchronous serial line; idles high.
- clr_rdy  in  1  consumer acknowledge; clears `rdy` and all flags.
- rx_data  out  DATA_BITS  last received word, LSB first on the wire.
- rdy  out  1  word valid; held until cleared.
- parity_err  out  1  parity mismatch in the word currently presented.
- frame_err  out  1  at least one stop bit was sampled low.
- overrun  out  1  a word completed while `rdy` was still set.

## Operation
- Synchroniser: RX passes through two flops before use. Both flops reset to 1 so that no false start is seen out of reset.
- FSM states are IDLE, START, DATA, PARITY, STOP. All of them reset to IDLE.
  - IDLE: a synchronised RX = 0 loads the baud counter with HALF = BAUD_DIV/2 (integer division) and moves to START.
  - START: at the sample point, RX = 1 means a glitch. Return to IDLE with no output change. RX = 0 moves to DATA and reloads the counter with BAUD_DIV.
  - DATA: sample DATA_BITS bits, shifting each in at the MSB so the first bit lands at bit 0. Then move to PARITY if PARITY_EN = 1, otherwise to STOP.
  - PARITY: sample one bit. parity_err is set when the XOR of data and the parity bit is not equal to PARITY_ODD.
  - STOP: sample STOP_BITS bits. Any low sample sets frame_err. After the last sample, return to IDLE without waiting for the bit to end. This allows resynchronisation on the next falling edge.
- Completion: rx_data, parity_err and frame_err are loaded from the frame together, and rdy is set. A frame with errors is still delivered.
- Overrun: if rdy = 1 at completion, set overrun and overwrite rx_data and the error flags. overrun is sticky until clr_rdy.
- clr_rdy clears rdy, parity_err, frame_err and overrun. rx_data holds its value.
- Completion and clr_rdy in the same cycle: completion wins. rdy stays 1 with the new flags, and overrun is cleared rather than set.
- Line held low (break): each frame completes with data 0 and frame_err = 1, and a new START is detected immediately.

## Timing
- Reset values: rdy, parity_err, frame_err and overrun are 0, rx_data = 0, FSM is in IDLE, synchroniser flops are 1. Reset mid-frame aborts the frame with no output.
- Definitions:
  - t0 = the edge on which the FSM leaves IDLE. This is 2 to 3 cycles after the RX pin falls.
  - Sample k (k = 0 is the start bit) is taken on edge t0 + HALF + k·BAUD_DIV.
  - K = DATA_BITS + PARITY_EN + STOP_BITS is the index of the last sample.
- rdy and the outputs update on edge t0 + HALF + K·BAUD_DIV + 1. For the defaults this is t0 + 49477.
- A glitch is rejected on edge t0 + HALF. The next start can be detected one cycle later.
- Counter width is $clog2(BAUD_DIV+1). The bit counter is 4 bits wide and never wraps within a frame.

## Structure
- Package `uart_pkg` holds:
  - the `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - the default BAUD_DIV constant;
  - the parity-mode localparams. These are shared with the future configurable transmitter.
- Sub-module `uart_baud_cnt` is a loadable down-counter. It has inputs `load` and `load_val` and outputs a 1-cycle `tick` when it reaches terminal count. It is reused by the transmitter.
- The top level contains the synchroniser, FSM, shift register and output/flag registers.

## Test plan
- 8N1, BAUD_DIV = 16, send 0xA5, then 0x3C with clr_rdy pulsed between them:
  - 0xA5: rdy rises at t0 + 153 with rx_data = 0xA5 and all flags 0.
  - 0x3C: rx_data = 0x3C and all flags 0.
- 8E1, BAUD_DIV = 16:
  - send 0x07 with parity bit 1: rdy with parity_err = 0;
  - send 0x07 with parity bit 0: parity_err = 1.
  - Repeat with PARITY_ODD = 1 and confirm the results are inverted.
- 7N2, send 0x55 with the second stop bit forced low: rx_data = 0x55 and frame_err = 1. A following clean frame with clr_rdy gives frame_err = 0.
- RX low pulse of 5 cycles at BAUD_DIV = 16: no rdy, and the FSM returns to IDLE. An immediately following 0x81 is received correctly.
- Overrun and collision:
  - two frames without clr_rdy: the second word is presented with overrun = 1;
  - clr_rdy asserted on the completion edge: rdy = 1 and overrun = 0.
- rst_n asserted during bit 4 of a frame:
  - all outputs go to 0 immediately;
  - after release with RX high, no rdy appears;
  - the next 0xFF frame is received correctly.
